// File: rtl/counter_ctrl_pkg.sv
// Shared types and helpers for the burst-counter controller.
// Build option: COUNTER_BURST_CTRL_FIXED_PRIO_EN selects fixed-priority arbitration.
package counter_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    localparam int NREQ_DEF  = 4;
    localparam int CNT_W_DEF = 4;

    // A length of 0 stands for 2^w, so (len-1) mod 2^w gives all-ones there.
    function automatic logic [31:0] len_last(input logic [31:0] len, input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (len - 32'd1) & mask;
    endfunction

endpackage

// File: rtl/counter_burst_ctrl_if.sv
// Requester-side bus of the burst-counter controller.
// Build option: COUNTER_BURST_CTRL_FIXED_PRIO_EN (no effect on this interface).
interface counter_burst_ctrl_if
    import counter_ctrl_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int IDX_W = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*CNT_W-1:0] req_len;
    logic                  pause;
    logic [NREQ-1:0]       req_ack;
    logic [CNT_W-1:0]      counter_out;
    logic                  busy;
    logic [IDX_W-1:0]      owner;
    logic [NREQ-1:0]       done;
    logic                  overflow_out;

    modport master (
        output req_valid, req_len, pause,
        input  req_ack, counter_out, busy, owner, done, overflow_out
    );

    modport slave (
        input  req_valid, req_len, pause,
        output req_ack, counter_out, busy, owner, done, overflow_out
    );

endinterface

// File: rtl/counter_burst_ctrl_rr_arbiter.sv
// Combinational arbiter: round-robin after ptr, or lowest index wins
// when COUNTER_BURST_CTRL_FIXED_PRIO_EN is defined (ptr port then absent).
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
`ifndef COUNTER_BURST_CTRL_FIXED_PRIO_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    always_comb begin
        int  idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
`ifdef COUNTER_BURST_CTRL_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !found) begin
                found      = 1'b1;
                gnt[i]     = 1'b1;
                gnt_idx    = IDX_W'(i);
            end
        end
`else
        // Search starts just after the last winner and wraps.
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx] && !found) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IDX_W'(idx);
            end
        end
`endif
    end

endmodule

// File: rtl/counter_burst_ctrl.sv
// Shares one CNT_W-bit up-counter among NREQ requesters, one burst at a time.
// Build option: COUNTER_BURST_CTRL_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module counter_burst_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic clk,
    input logic reset,
    counter_burst_ctrl_if.slave bus
);
    localparam int IDX_W = $clog2(NREQ);

    state_t           state;
    logic [CNT_W-1:0] len_q;
    logic [NREQ-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             at_last;

`ifndef COUNTER_BURST_CTRL_FIXED_PRIO_EN
    logic [IDX_W-1:0] rr_ptr;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req     (bus.req_valid),
`ifndef COUNTER_BURST_CTRL_FIXED_PRIO_EN
        .ptr     (rr_ptr),
`endif
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign at_last = 32'(bus.counter_out) == len_last(32'(len_q), CNT_W);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            len_q            <= '0;
            bus.req_ack      <= '0;
            bus.counter_out  <= '0;
            bus.busy         <= 1'b0;
            bus.owner        <= '0;
            bus.done         <= '0;
            bus.overflow_out <= 1'b0;
`ifndef COUNTER_BURST_CTRL_FIXED_PRIO_EN
            rr_ptr           <= IDX_W'(NREQ - 1);
`endif
        end else begin
            bus.req_ack      <= '0;
            bus.done         <= '0;
            bus.overflow_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        bus.req_ack     <= gnt;
                        bus.owner       <= gnt_idx;
                        len_q           <= bus.req_len[int'(gnt_idx)*CNT_W +: CNT_W];
                        bus.counter_out <= '0;
                        bus.busy        <= 1'b1;
                        state           <= COUNT;
`ifndef COUNTER_BURST_CTRL_FIXED_PRIO_EN
                        rr_ptr          <= gnt_idx;
`endif
                    end
                end
                COUNT: begin
                    if (!bus.pause) begin
                        if (at_last) begin
                            bus.counter_out  <= '0;
                            bus.done         <= NREQ'(1) << bus.owner;
                            bus.overflow_out <= (len_q == '0);
                            state            <= DONE;
                        end else begin
                            bus.counter_out <= bus.counter_out + 1'b1;
                        end
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_counter_burst_ctrl.sv
// Scoreboard bench for counter_burst_ctrl: directed cases then random traffic.
// Honours COUNTER_BURST_CTRL_FIXED_PRIO_EN in its reference model.
module tb_counter_burst_ctrl;
    import counter_ctrl_pkg::*;

    localparam int NREQ  = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    counter_burst_ctrl_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();
    counter_burst_ctrl #(.NREQ(NREQ), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct { int cyc; int idx; bit ovf; } ev_t;
    typedef struct { int cyc; int val; } cv_t;

    ev_t ack_q[$];
    ev_t done_q[$];
    cv_t cnt_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [NREQ-1:0]       want = '0;
    logic [NREQ*CNT_W-1:0] lens = '0;
    logic                  pz   = 1'b0;
    bit                    hold = 1'b0;

    // Reference model: 0 idle, 1 counting (m_rem counts still owed), 2 done cycle.
    int m_st = 0, m_rem = 0, m_L = 0, m_owner = 0, m_ptr = NREQ - 1;
    bit m_ovf = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, bit ok, string got, string req);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s @cyc %0d: got %s, required %s", name, cyc, got, req);
        end
    endtask

    function automatic int pick();
`ifdef COUNTER_BURST_CTRL_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (want[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (want[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
`endif
        return -1;
    endfunction

    function automatic int len_of(int i);
        int v;
        v = int'(lens[i*CNT_W +: CNT_W]);
        return (v == 0) ? (1 << CNT_W) : v;
    endfunction

    task automatic set_len(int i, int v);
        lens[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic model_step();
        int w;
        case (m_st)
            0: begin
                w = pick();
                if (w >= 0) begin
                    ack_q.push_back('{cyc + 1, w, 1'b0});
                    m_owner = w;
                    m_L     = len_of(w);
                    m_rem   = m_L;
                    m_ovf   = (m_L == (1 << CNT_W));
                    m_ptr   = w;
                    m_st    = 1;
                    if (!hold) want[w] = 1'b0;
                end
            end
            1: begin
                cnt_q.push_back('{cyc, m_L - m_rem});
                if (!pz) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        done_q.push_back('{cyc + 1, m_owner, m_ovf});
                        m_st = 2;
                    end
                end
            end
            default: begin
                cnt_q.push_back('{cyc, 0});
                m_st = 0;
            end
        endcase
    endtask

    task automatic tick();
        bus.req_valid = want;
        bus.req_len   = lens;
        bus.pause     = pz;
        model_step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("reset_zero",
            {bus.req_ack, bus.counter_out, bus.busy, bus.owner, bus.done, bus.overflow_out} == '0,
            $sformatf("ack=%b cnt=%0d busy=%b owner=%0d done=%b ovf=%b", bus.req_ack,
                      bus.counter_out, bus.busy, bus.owner, bus.done, bus.overflow_out),
            "all zero");
        ack_q.delete();
        done_q.delete();
        cnt_q.delete();
        m_st  = 0;
        m_ptr = NREQ - 1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic run_to_count(int v, string name);
        for (int b = 0; b < 60 && !(m_st == 1 && m_L - m_rem == v); b++) tick();
        chk(name, m_st == 1 && m_L - m_rem == v, "count not reached", $sformatf("count %0d", v));
    endtask

    // Monitor: pops expectations only when the DUT presents something.
    always @(negedge clk) begin : mon
        ev_t e;
        cv_t c;
        if (!reset) begin
            if (|bus.req_ack) begin
                if (ack_q.size() == 0) chk("ack_unexpected", 1'b0, $sformatf("%b", bus.req_ack), "no ack");
                else begin
                    e = ack_q.pop_front();
                    chk("ack", e.cyc == cyc && bus.req_ack == (NREQ'(1) << e.idx) && int'(bus.owner) == e.idx,
                        $sformatf("ack=%b owner=%0d cyc=%0d", bus.req_ack, bus.owner, cyc),
                        $sformatf("req %0d at cyc %0d", e.idx, e.cyc));
                end
            end
            if (|bus.done || bus.overflow_out) begin
                if (done_q.size() == 0) chk("done_unexpected", 1'b0,
                    $sformatf("done=%b ovf=%b", bus.done, bus.overflow_out), "no done");
                else begin
                    e = done_q.pop_front();
                    chk("done", e.cyc == cyc && bus.done == (NREQ'(1) << e.idx) && bus.overflow_out == e.ovf,
                        $sformatf("done=%b ovf=%b cyc=%0d", bus.done, bus.overflow_out, cyc),
                        $sformatf("req %0d ovf %0d at cyc %0d", e.idx, e.ovf, e.cyc));
                end
            end
            if (bus.busy) begin
                if (cnt_q.size() == 0) chk("busy_unexpected", 1'b0, "busy", "idle");
                else begin
                    c = cnt_q.pop_front();
                    chk("count", c.cyc == cyc && int'(bus.counter_out) == c.val,
                        $sformatf("cnt=%0d cyc=%0d", bus.counter_out, cyc),
                        $sformatf("cnt=%0d cyc=%0d", c.val, c.cyc));
                end
            end else begin
                chk("idle_count", bus.counter_out == '0, $sformatf("%0d", bus.counter_out), "0");
            end
        end
    end

    initial begin
        bus.req_valid = '0;
        bus.req_len   = '0;
        bus.pause     = 1'b0;
        #1;
        do_reset();

        // single burst of 3
        want = 4'b0001; set_len(0, 3);
        repeat (8) tick();

        // all requesters held with length 1
        hold = 1'b1; want = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        repeat (16) tick();
        hold = 1'b0; want = '0;
        repeat (4) tick();

        // full-range burst with wrap
        want = 4'b0001; set_len(0, 0);
        repeat (22) tick();

        // pause held for 4 cycles at count 2
        want = 4'b0001; set_len(0, 5);
        run_to_count(2, "reach_pause_point");
        pz = 1'b1; repeat (4) tick();
        pz = 1'b0; repeat (8) tick();

        // request dropped and length altered after ack
        want = 4'b0100; set_len(2, 4);
        tick();
        set_len(2, 9);
        repeat (8) tick();

        // reset mid-burst, then all requesters: req 0 must win first
        want = 4'b0001; set_len(0, 12);
        run_to_count(7, "reach_reset_point");
        do_reset();
        want = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_len(i, 2);
        repeat (20) tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!want[i] && $urandom_range(0, 3) == 0) begin
                    want[i] = 1'b1;
                    set_len(i, int'($urandom_range(0, 15)));
                end else if (want[i] && $urandom_range(0, 15) == 0) begin
                    want[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    set_len(i, int'($urandom_range(0, 15)));
                end
            end
            pz = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 249) == 0) do_reset();
            else tick();
        end

        want = '0; pz = 1'b0;
        repeat (24) tick();
        chk("ack_drain", ack_q.size() == 0, $sformatf("%0d left", ack_q.size()), "0 left");
        chk("done_drain", done_q.size() == 0, $sformatf("%0d left", done_q.size()), "0 left");
        chk("count_drain", cnt_q.size() == 0, $sformatf("%0d left", cnt_q.size()), "0 left");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
